// File: rtl/tms1000_panel_responder.sv
// Board-side keyboard matrix and multiplexed display for a TMS1000 core:
// debounces keys, returns K rows for strobed R columns, captures O per digit.
module tms1000_panel_responder #(
  parameter int NUM_COLS       = 11,
  parameter int TICK_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SETTLE         = 8,
  parameter int TIMEOUT        = 60000
) (
  input  logic                  raw_clk,
  input  logic                  reset,
  input  logic [NUM_COLS-1:0]   pins_r,
  input  logic [7:0]            pins_o,
  input  logic [4*NUM_COLS-1:0] keys,
  output logic [3:0]            pins_k,
  output logic [4*NUM_COLS-1:0] deb_keys,
  output logic [8*NUM_COLS-1:0] digits,
  output logic [NUM_COLS-1:0]   digit_valid,
  output logic                  key_event,
  output logic [5:0]            key_index,
  output logic                  key_pressed
);

  localparam int NK = 4 * NUM_COLS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int AW = $clog2(TIMEOUT + 1);

  logic [NUM_COLS-1:0] r_q;
  logic [7:0]          o_q;
  logic [7:0]          o_prev;
  logic [NK-1:0]       keys_q;
  logic [TW-1:0]       tick_cnt;
  logic                tick;

  logic [DW-1:0]       cnt      [NK];
  logic [DW-1:0]       cnt_next [NK];
  logic [NK-1:0]       deb_next;
  logic [NK-1:0]       flips;
  logic [5:0]          first_idx;
  logic                first_val;
  logic [3:0]          k_next;

  logic [SW-1:0]       settle   [NUM_COLS];
  logic [AW-1:0]       age      [NUM_COLS];
  logic                o_stable;
  logic [NUM_COLS-1:0] cap;

  assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
  assign o_stable = (o_q == o_prev);

  always_comb begin
    deb_next  = deb_keys;
    flips     = '0;
    cnt_next  = cnt;
    first_idx = '0;
    first_val = 1'b0;
    k_next    = '0;
    if (tick) begin
      for (int i = 0; i < NK; i++) begin
        if (keys_q[i] == deb_keys[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == DW'(DEBOUNCE_TICKS - 1)) begin
          deb_next[i] = keys_q[i];
          cnt_next[i] = '0;
          flips[i]    = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
    // Descending scan so the lowest flipped index is the one that sticks.
    for (int i = NK - 1; i >= 0; i--) begin
      if (flips[i]) begin
        first_idx = 6'(i);
        first_val = deb_next[i];
      end
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      if (r_q[c]) k_next = k_next | deb_keys[4*c +: 4];
    end
  end

  always_comb begin
    cap = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      cap[c] = r_q[c] && o_stable && (settle[c] == SW'(SETTLE - 1));
    end
  end

  // key_event is a single-cycle strobe with no back-pressure: key_index and
  // key_pressed are meaningful only in the cycle key_event is high.
  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      r_q         <= '0;
      o_q         <= '0;
      o_prev      <= '0;
      keys_q      <= '0;
      tick_cnt    <= '0;
      deb_keys    <= '0;
      key_event   <= 1'b0;
      key_index   <= '0;
      key_pressed <= 1'b0;
      pins_k      <= '0;
      digits      <= '0;
      digit_valid <= '0;
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        settle[c] <= '0;
        age[c]    <= '0;
      end
    end else begin
      r_q         <= pins_r;
      o_q         <= pins_o;
      o_prev      <= o_q;
      keys_q      <= keys;
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      deb_keys    <= deb_next;
      cnt         <= cnt_next;
      key_event   <= |flips;
      key_index   <= first_idx;
      key_pressed <= first_val;
      pins_k      <= k_next;
      for (int c = 0; c < NUM_COLS; c++) begin
        if (!r_q[c] || !o_stable) begin
          settle[c] <= '0;
        end else if (settle[c] != SW'(SETTLE)) begin
          settle[c] <= settle[c] + 1'b1;
        end
        // A capture in the same cycle as a timeout wins.
        if (cap[c]) begin
          digits[8*c +: 8] <= o_q;
          digit_valid[c]   <= 1'b1;
          age[c]           <= '0;
        end else if (age[c] != AW'(TIMEOUT)) begin
          age[c] <= age[c] + 1'b1;
          if (age[c] == AW'(TIMEOUT - 1)) begin
            digit_valid[c]   <= 1'b0;
            digits[8*c +: 8] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tms1000_panel_responder.sv
// Bench for tms1000_panel_responder: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model and a key-event queue.
module tb_tms1000_panel_responder;

  localparam int NUM_COLS       = 11;
  localparam int TICK_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 4;
  localparam int SETTLE         = 8;
  localparam int TIMEOUT        = 100;
  localparam int NK             = 4 * NUM_COLS;

  logic                  raw_clk;
  logic                  reset;
  logic [NUM_COLS-1:0]   pins_r;
  logic [7:0]            pins_o;
  logic [NK-1:0]         keys;
  logic [3:0]            pins_k;
  logic [NK-1:0]         deb_keys;
  logic [8*NUM_COLS-1:0] digits;
  logic [NUM_COLS-1:0]   digit_valid;
  logic                  key_event;
  logic [5:0]            key_index;
  logic                  key_pressed;

  tms1000_panel_responder #(
    .NUM_COLS(NUM_COLS), .TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .raw_clk(raw_clk), .reset(reset), .pins_r(pins_r), .pins_o(pins_o),
    .keys(keys), .pins_k(pins_k), .deb_keys(deb_keys), .digits(digits),
    .digit_valid(digit_valid), .key_event(key_event), .key_index(key_index),
    .key_pressed(key_pressed)
  );

  // clock / reset
  initial begin
    raw_clk = 1'b0;
    forever #5 raw_clk = ~raw_clk;
  end

  int checks = 0;
  int errors = 0;
  int ev_seen = 0;
  int cycle = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // behavioural model: registered inputs, per-key run of differing samples,
  // per-column run of stable strobed cycles, cycles since last capture
  logic [NUM_COLS-1:0] m_r_q;
  logic [7:0]          m_o_q, m_o_prev;
  logic [NK-1:0]       m_keys_q, m_deb;
  logic [3:0]          m_k;
  logic [7:0]          m_dig [NUM_COLS];
  logic [NUM_COLS-1:0] m_val;
  int                  m_tick_cnt;
  int                  m_run [NK];
  int                  m_stable [NUM_COLS];
  int                  m_since [NUM_COLS];
  int                  m_cap_cycle [NUM_COLS];
  logic [6:0]          exp_q [$];

  task automatic model_reset();
    m_r_q = '0; m_o_q = '0; m_o_prev = '0; m_keys_q = '0; m_deb = '0;
    m_k = '0; m_val = '0; m_tick_cnt = 0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
    for (int c = 0; c < NUM_COLS; c++) begin
      m_dig[c] = '0; m_stable[c] = 0; m_since[c] = 0; m_cap_cycle[c] = -1000;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [3:0] newk;
    int first;
    newk = '0;
    for (int c = 0; c < NUM_COLS; c++)
      if (m_r_q[c]) newk = newk | m_deb[4*c +: 4];
    if (m_tick_cnt == TICK_DIV - 1) begin
      first = -1;
      for (int i = 0; i < NK; i++) begin
        if (m_keys_q[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DEBOUNCE_TICKS) begin
            m_deb[i] = m_keys_q[i];
            m_run[i] = 0;
            if (first < 0) begin
              first = i;
              exp_q.push_back({m_keys_q[i], 6'(i)});
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_tick_cnt = 0;
    end else begin
      m_tick_cnt++;
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      if (m_r_q[c] && (m_o_q == m_o_prev)) begin
        if (m_stable[c] <= SETTLE) m_stable[c]++;
      end else begin
        m_stable[c] = 0;
      end
      if (m_stable[c] == SETTLE && m_r_q[c] && (m_o_q == m_o_prev)) begin
        m_dig[c] = m_o_q; m_val[c] = 1'b1; m_since[c] = 0; m_cap_cycle[c] = cycle;
      end else if (m_since[c] < TIMEOUT) begin
        m_since[c]++;
        if (m_since[c] == TIMEOUT) begin
          m_val[c] = 1'b0; m_dig[c] = '0;
        end
      end
    end
    m_k = newk;
    m_o_prev = m_o_q;
    m_r_q = pins_r; m_o_q = pins_o; m_keys_q = keys;
  endtask

  function automatic logic [8*NUM_COLS-1:0] m_dig_flat();
    logic [8*NUM_COLS-1:0] f;
    for (int c = 0; c < NUM_COLS; c++) f[8*c +: 8] = m_dig[c];
    return f;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge raw_clk);
      cycle++;
      if (reset) model_reset();
      else model_step();
    end
  end

  // monitor: outputs against model each cycle, key events against the queue
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge raw_clk);
      check("pins_k", 96'(pins_k), 96'(m_k));
      check("deb_keys", 96'(deb_keys), 96'(m_deb));
      check("digits", 96'(digits), 96'(m_dig_flat()));
      check("digit_valid", 96'(digit_valid), 96'(m_val));
      if (key_event) ev_seen++;
      if (key_event || exp_q.size() > 0) begin
        if (exp_q.size() == 0) begin
          check("key_event_spurious", 96'(key_event), 96'(0));
        end else begin
          e = exp_q.pop_front();
          check("key_event_missing", 96'(key_event), 96'(1));
          check("key_info", 96'({key_pressed, key_index}), 96'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycle(input int target);
    while (cycle < target) @(negedge raw_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pins_k"}, 96'(pins_k), 96'(0));
    check({tag, "_deb_keys"}, 96'(deb_keys), 96'(0));
    check({tag, "_digits"}, 96'(digits), 96'(0));
    check({tag, "_digit_valid"}, 96'(digit_valid), 96'(0));
    check({tag, "_key_event"}, 96'(key_event), 96'(0));
    check({tag, "_key_index"}, 96'(key_index), 96'(0));
    check({tag, "_key_pressed"}, 96'(key_pressed), 96'(0));
  endtask

  // driver
  initial begin
    int e1, e2, k;
    reset = 1'b1; pins_r = '0; pins_o = '0; keys = '0;
    repeat (3) @(negedge raw_clk);
    reset = 1'b0;
    check_all_zero("reset_init");

    // debounce: steady key accepted, short glitch rejected
    keys[5] = 1'b1;
    repeat (30) @(negedge raw_clk);
    check("deb_key5", 96'(deb_keys[5]), 96'(1));
    check("deb_key5_events", 96'(ev_seen), 96'(1));
    keys[6] = 1'b1;
    repeat (6) @(negedge raw_clk);
    keys[6] = 1'b0;
    repeat (30) @(negedge raw_clk);
    check("glitch_key6", 96'(deb_keys[6]), 96'(0));
    check("glitch_events", 96'(ev_seen), 96'(1));

    // K return: column 1 = 1010, column 3 = 0001
    keys[7] = 1'b1; keys[12] = 1'b1;
    repeat (30) @(negedge raw_clk);
    pins_r = 11'b00000000010;
    repeat (2) @(negedge raw_clk);
    check("k_col1", 96'(pins_k), 96'(4'b1010));
    pins_r = 11'b00000001010;
    repeat (2) @(negedge raw_clk);
    check("k_col1_col3", 96'(pins_k), 96'(4'b1011));
    pins_r = '0;
    repeat (2) @(negedge raw_clk);
    check("k_none", 96'(pins_k), 96'(0));

    // capture and recapture on column 2
    pins_o = 8'h6D; pins_r = 11'b00000000100;
    repeat (12) @(negedge raw_clk);
    check("cap_digit2", 96'(digits[23:16]), 96'(8'h6D));
    check("cap_valid2", 96'(digit_valid[2]), 96'(1));
    pins_o = 8'h30;
    repeat (12) @(negedge raw_clk);
    check("recap_digit2", 96'(digits[23:16]), 96'(8'h30));
    pins_r = '0;

    // timeout on column 0, then a capture landing on the timeout cycle
    pins_o = 8'h5B; pins_r = 11'b00000000001;
    repeat (12) @(negedge raw_clk);
    pins_r = '0;
    e1 = m_cap_cycle[0];
    wait_cycle(e1 + TIMEOUT - 1);
    check("timeout_before", 96'(digit_valid[0]), 96'(1));
    @(negedge raw_clk);
    check("timeout_valid", 96'(digit_valid[0]), 96'(0));
    check("timeout_blank", 96'(digits[7:0]), 96'(0));
    pins_r = 11'b00000000001;
    repeat (12) @(negedge raw_clk);
    pins_r = '0;
    e2 = m_cap_cycle[0];
    wait_cycle(e2 + TIMEOUT - SETTLE - 1);
    pins_r = 11'b00000000001;
    wait_cycle(e2 + TIMEOUT);
    check("cap_wins_valid", 96'(digit_valid[0]), 96'(1));
    check("cap_wins_digit", 96'(digits[7:0]), 96'(8'h5B));
    repeat (3) @(negedge raw_clk);
    pins_r = '0;

    // two columns strobed together
    pins_o = 8'h7F; pins_r = 11'b00010010000;
    repeat (12) @(negedge raw_clk);
    check("multi_digit4", 96'(digits[39:32]), 96'(8'h7F));
    check("multi_digit7", 96'(digits[63:56]), 96'(8'h7F));
    pins_r = '0;

    // asynchronous reset mid-run with everything active
    keys = '1; pins_r = '1;
    repeat (40) @(negedge raw_clk);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_async");
    repeat (3) @(negedge raw_clk);
    check_all_zero("reset_held");
    reset = 1'b0;

    // random traffic
    for (int n = 0; n < 2500; n++) begin
      @(negedge raw_clk);
      if ($urandom_range(5, 0) == 0) begin
        case ($urandom_range(2, 0))
          0: pins_r = '0;
          1: pins_r = 11'(1) << $urandom_range(NUM_COLS - 1, 0);
          default: pins_r = 11'($urandom);
        endcase
      end
      if ($urandom_range(9, 0) == 0) pins_o = 8'($urandom);
      if ($urandom_range(24, 0) == 0) begin
        k = $urandom_range(NK - 1, 0);
        keys[k] = ~keys[k];
      end
    end
    pins_r = '0;
    repeat (20) @(negedge raw_clk);
    check("exp_q_drained", 96'(exp_q.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tms1000_panel_responder.md
Name: tms1000_panel_responder

Overview:
- Board-side counterpart to the TMS1000 core's R/O/K pins. Acts as the keyboard matrix and multiplexed display the core scans.
- Watches the R strobe lines. Returns debounced key rows on K for whichever columns are strobed.
- Captures the O segment byte driven during each strobe into a per-digit frame buffer for the LED/debug logic.
- Same clock domain as the core (the core's clk is divided from raw_clk).

Parameters:
- NUM_COLS, 11: R strobe columns; also the number of digits.
- TICK_DIV, 12000: raw_clk cycles per debounce sample tick (1 kHz at 12 MHz).
- DEBOUNCE_TICKS, 4: consecutive differing samples needed to flip a debounced key.
- SETTLE, 8: raw_clk cycles a strobe must stay high before O is captured.
- TIMEOUT, 60000: raw_clk cycles without a capture before a digit is blanked.

Ports:
- raw_clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- pins_r, input, NUM_COLS: R strobes from the core, active high.
- pins_o, input, 8: O segment outputs from the core.
- keys, input, 4*NUM_COLS: raw switch matrix, active high. Bit 4*c+k is row k of column c.
- pins_k, output, 4: K lines to the core.
- deb_keys, output, 4*NUM_COLS: debounced key state, same layout as keys.
- digits, output, 8*NUM_COLS: captured segment byte per column; digit c is bits 8c+7:8c.
- digit_valid, output, NUM_COLS: digit c has been captured within the last TIMEOUT cycles.
- key_event, output, 1: one-cycle pulse when any debounced key changes.
- key_index, output, 6: lowest index of the keys that changed; valid only with key_event.
- key_pressed, output, 1: new debounced value of key_index; valid only with key_event.

Behaviour:
- Reset (asynchronous, active-high): every output and all internal state go to 0. This covers pins_k, deb_keys, digits, digit_valid, key_event, key_index, key_pressed, and all counters and input registers. Asserting reset mid-capture or mid-debounce discards all progress.
- Input stage: pins_r, pins_o and keys are registered once (r_q, o_q, keys_q). All logic below uses the registered copies.
- Tick counter: counts 0..TICK_DIV-1, then wraps. tick is high for one cycle at wrap.
- Debounce, per key i, evaluated on tick only:
  - keys_q[i] == deb_keys[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_TICKS-1: deb_keys[i] <= keys_q[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Result: a change is accepted on the DEBOUNCE_TICKS-th consecutive differing tick. A single-tick glitch resets the count.
- Key event: in the cycle after any deb_keys bit flips, key_event is high for 1 cycle. key_index is the lowest flipped index and key_pressed is its new value. Keys that flip on the same tick at higher indices produce no event of their own, but deb_keys still reflects them.
- K return: pins_k <= OR over all c with r_q[c]==1 of deb_keys[4c+3:4c].
  - No strobe high gives pins_k = 0. Multiple strobes give the OR of their columns.
  - Latency: 2 raw_clk cycles from a pins_r change to pins_k (input register plus output register). The core samples K at least 40 raw_clk cycles after SETR, so this is safe.
- Display capture, per column c:
  - settle[c] resets to 0 whenever r_q[c]==0 or o_q differs from the previous cycle's o_q.
  - Otherwise settle[c] increments, saturating at SETTLE.
  - On the cycle settle[c] reaches SETTLE: digits[c] <= o_q, digit_valid[c] <= 1, age[c] <= 0.
  - A strobe held high captures exactly once until it drops or O changes. O changing while strobed restarts settle and causes a recapture.
- Timeout, per column c:
  - age[c] increments every cycle, saturating at TIMEOUT.
  - On reaching TIMEOUT: digit_valid[c] <= 0 and digits[c] <= 0 (blank).
  - A capture and a timeout in the same cycle: the capture wins.
- Simultaneous strobes: every high column captures the same O byte independently.
- pins_r bits at index >= NUM_COLS do not exist; when NUM_COLS < 11 the core's upper R pins are left unconnected.

Test Plan:
- Reset: assert reset mid-run with keys=all 1 and a strobe active. Required: all outputs 0 immediately and asynchronously; they stay 0 until reset drops.
- Debounce: hold keys[5]=1 with TICK_DIV=4, DEBOUNCE_TICKS=4. Required: deb_keys[5] rises on the 4th tick; key_event pulses once with key_index=5, key_pressed=1. A 2-tick glitch on keys[6] gives no change.
- K return: deb_keys column 1 = 4'b1010, column 3 = 4'b0001. Drive pins_r=11'b00000000010: pins_k=4'b1010 after 2 cycles. pins_r=11'b00000001010: pins_k=4'b1011. pins_r=0: pins_k=0.
- Capture: pins_r[2]=1, pins_o=8'h6D held 8 cycles. Required: digits[2]=8'h6D and digit_valid[2]=1, captured once. Changing O to 8'h30 while strobed recaptures 8'h30 after SETTLE.
- Timeout: capture digit 0, then never strobe it again (TIMEOUT=100). Required: digit_valid[0]=0 and digits[0]=0 exactly 100 cycles after the capture. A strobe landing in that same cycle keeps it valid.
- Multi-strobe: pins_r[4] and pins_r[7] both high with O=8'h7F. Required: digits[4] = digits[7] = 8'h7F on the same cycle.
